// File: rtl/seg_pkg.sv
// Shared constants and address arithmetic for the segmented address unit.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Holds the segment index names, the default parameter values and the
// physical address helper used by seg_addr_unit.
package seg_pkg;

    // Segment register indices
    localparam int CS = 0;
    localparam int DS = 1;
    localparam int SS = 2;
    localparam int ES = 3;
    localparam int FS = 4;
    localparam int GS = 5;

    // Default configuration
    localparam int DEF_NUM_SEGS = 4;
    localparam int DEF_SEG_W    = 16;
    localparam int DEF_OFF_W    = 16;
    localparam int DEF_SHIFT    = 4;
    localparam int DEF_ADDR_W   = 20;

    // (seg << shift) + off on wide operands; the caller truncates to its
    // address width, which gives the modulo-2^ADDR_W wrap.
    function automatic logic [63:0] phys_addr(input logic [63:0] seg,
                                              input logic [63:0] off,
                                              input int          shift);
        return (seg << shift) + off;
    endfunction

endpackage

// File: rtl/seg_regfile.sv
// Segment (and optional limit) register file with write-through read port.
// Latency: writes land at the clock edge; the read port is combinational.
// Backpressure: none; writes are always accepted, out-of-range selects ignored.
//
// Ports: clk/rst, write port (wr_en, wr_sel, wr_data), optional limit write
// port (lim_wr_en, lim_data, shares wr_sel), read port (rd_sel -> rd_seg,
// rd_lim, rd_valid). rd_valid is 0 for a select with no register behind it.
// Macro SEG_LIMIT_CHECK_EN adds the limit registers and their ports.
module seg_regfile #(
    parameter int NUM_SEGS = 4,
    parameter int SEG_W    = 16,
    parameter int OFF_W    = 16,
    parameter int SEL_W    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [SEL_W-1:0] wr_sel,
    input  logic [SEG_W-1:0] wr_data,
`ifdef SEG_LIMIT_CHECK_EN
    input  logic             lim_wr_en,
    input  logic [OFF_W-1:0] lim_data,
    output logic [OFF_W-1:0] rd_lim,
`endif
    input  logic [SEL_W-1:0] rd_sel,
    output logic [SEG_W-1:0] rd_seg,
    output logic             rd_valid
);

    logic [SEG_W-1:0] seg_q [NUM_SEGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SEGS; i++) seg_q[i] <= '0;
        end else begin
            // Only selects that match a real register write anything.
            for (int i = 0; i < NUM_SEGS; i++) begin
                if (wr_en && wr_sel == SEL_W'(i)) seg_q[i] <= wr_data;
            end
        end
    end

    always_comb begin
        rd_seg   = '0;
        rd_valid = 1'b0;
        for (int i = 0; i < NUM_SEGS; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                rd_seg   = seg_q[i];
                rd_valid = 1'b1;
            end
        end
        // Same-cycle write to the register being read is passed through.
        if (rd_valid && wr_en && wr_sel == rd_sel) rd_seg = wr_data;
    end

`ifdef SEG_LIMIT_CHECK_EN
    logic [OFF_W-1:0] lim_q [NUM_SEGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SEGS; i++) lim_q[i] <= '1;
        end else begin
            for (int i = 0; i < NUM_SEGS; i++) begin
                if (lim_wr_en && wr_sel == SEL_W'(i)) lim_q[i] <= lim_data;
            end
        end
    end

    always_comb begin
        rd_lim = '1;
        for (int i = 0; i < NUM_SEGS; i++) begin
            if (rd_sel == SEL_W'(i)) rd_lim = lim_q[i];
        end
        if (rd_valid && lim_wr_en && wr_sel == rd_sel) rd_lim = lim_data;
    end
`endif

endmodule

// File: rtl/seg_addr_unit.sv
// Segment:offset to physical address translator with override prefix latch.
// Latency: 1 cycle from request accept to rsp_valid; one response per cycle.
// Backpressure: req_ready = !rsp_valid || rsp_ready; response held while stalled.
//
// Ports: clk/rst; segment write (wr_en, wr_sel, wr_data); limit write
// (lim_wr_en, lim_data, target chosen by wr_sel); override prefix
// (ovr_valid, ovr_sel); request (req_valid/req_ready, req_def_sel, req_off);
// response (rsp_valid/rsp_ready, rsp_addr, rsp_seg, rsp_fault).
// Macro SEG_LIMIT_CHECK_EN enables per-segment limit checking.
module seg_addr_unit
    import seg_pkg::*;
#(
    parameter  int NUM_SEGS = DEF_NUM_SEGS,
    parameter  int SEG_W    = DEF_SEG_W,
    parameter  int OFF_W    = DEF_OFF_W,
    parameter  int SHIFT    = DEF_SHIFT,
    parameter  int ADDR_W   = DEF_ADDR_W,
    localparam int SEL_W    = (NUM_SEGS > 1) ? $clog2(NUM_SEGS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [SEL_W-1:0]  wr_sel,
    input  logic [SEG_W-1:0]  wr_data,
    input  logic              lim_wr_en,
    input  logic [OFF_W-1:0]  lim_data,
    input  logic              ovr_valid,
    input  logic [SEL_W-1:0]  ovr_sel,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [SEL_W-1:0]  req_def_sel,
    input  logic [OFF_W-1:0]  req_off,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [SEG_W-1:0]  rsp_seg,
    output logic              rsp_fault
);

    logic             pend_vld;
    logic [SEL_W-1:0] pend_sel;
    logic [SEL_W-1:0] eff_sel;
    logic [SEG_W-1:0] seg_val;
    logic             seg_ok;
    logic             accept;
    logic             fault_nxt;
    logic [ADDR_W-1:0] addr_nxt;

    assign req_ready = !rsp_valid || rsp_ready;
    assign accept    = req_valid && req_ready;

    // A prefix in the accept cycle beats a latched one, which beats the default.
    always_comb begin
        eff_sel = req_def_sel;
        if (ovr_valid)     eff_sel = ovr_sel;
        else if (pend_vld) eff_sel = pend_sel;
    end

`ifdef SEG_LIMIT_CHECK_EN
    logic [OFF_W-1:0] lim_val;

    seg_regfile #(
        .NUM_SEGS (NUM_SEGS),
        .SEG_W    (SEG_W),
        .OFF_W    (OFF_W),
        .SEL_W    (SEL_W)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .lim_wr_en (lim_wr_en),
        .lim_data  (lim_data),
        .rd_lim    (lim_val),
        .rd_sel    (eff_sel),
        .rd_seg    (seg_val),
        .rd_valid  (seg_ok)
    );

    assign fault_nxt = !seg_ok || (req_off > lim_val);
`else
    logic lim_unused;
    assign lim_unused = ^{lim_wr_en, lim_data};

    seg_regfile #(
        .NUM_SEGS (NUM_SEGS),
        .SEG_W    (SEG_W),
        .OFF_W    (OFF_W),
        .SEL_W    (SEL_W)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_sel   (wr_sel),
        .wr_data  (wr_data),
        .rd_sel   (eff_sel),
        .rd_seg   (seg_val),
        .rd_valid (seg_ok)
    );

    assign fault_nxt = !seg_ok;
`endif

    // seg_val is already 0 for a select with no register behind it.
    assign addr_nxt = ADDR_W'(phys_addr(64'(seg_val), 64'(req_off), SHIFT));

    // Override latch: any accept consumes it, otherwise the newest prefix wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_vld <= 1'b0;
            pend_sel <= '0;
        end else if (accept) begin
            pend_vld <= 1'b0;
        end else if (ovr_valid) begin
            pend_vld <= 1'b1;
            pend_sel <= ovr_sel;
        end
    end

    // Response register: loads on accept, holds while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_addr  <= '0;
            rsp_seg   <= '0;
            rsp_fault <= 1'b0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_addr  <= addr_nxt;
            rsp_seg   <= seg_val;
            rsp_fault <= fault_nxt;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: doc/seg_addr_unit.md
SEG_ADDR_UNIT -- requirements
Module: seg_addr_unit

Interface
REQ-001 The block SHALL have these parameters, one per line:
- NUM_SEGS, 4, number of segment registers (4..8).
- SEG_W, 16, segment register width.
- OFF_W, 16, offset width.
- SHIFT, 4, left shift applied to the segment base.
- ADDR_W, 20, physical address width.
- SEL_W is derived as clog2(NUM_SEGS), minimum 1.

REQ-002 The block SHALL have these ports, one per line:
- clk in 1, single clock; all state on its rising edge.
- rst in 1, asynchronous, active-high reset.
- wr_en in 1, segment register write strobe.
- wr_sel in SEL_W, segment register to write.
- wr_data in SEG_W, segment write data.
- lim_wr_en in 1, limit register write strobe.
- lim_data in OFF_W, limit write data; the target register is selected by wr_sel.
- ovr_valid in 1, segment-override prefix strobe.
- ovr_sel in SEL_W, override segment.
- req_valid in 1, address request valid.
- req_ready out 1, request accepted when req_valid and req_ready are both 1.
- req_def_sel in SEL_W, default segment for the request.
- req_off in OFF_W, request offset.
- rsp_valid out 1, response valid.
- rsp_ready in 1, response consumed when rsp_valid and rsp_ready are both 1.
- rsp_addr out ADDR_W, physical address.
- rsp_seg out SEG_W, segment value used for the address.
- rsp_fault out 1, limit violation flag.

Function
REQ-003 A segment register write SHALL update the selected register at the clock edge; a wr_sel value of NUM_SEGS or above SHALL be ignored.
REQ-004 Request handshake:
- req_ready SHALL equal (!rsp_valid || rsp_ready).
- An accepted request SHALL produce rsp_valid=1 on the next cycle (latency 1).
- Back-to-back requests SHALL sustain one response per cycle.
REQ-005 While rsp_valid=1 and rsp_ready=0, rsp_addr, rsp_seg and rsp_fault SHALL hold stable.
REQ-006 rsp_valid SHALL clear after a consume cycle that has no new accept.
REQ-007 Effective segment select SHALL be chosen in this priority order:
- ovr_sel, if ovr_valid is 1 in the accept cycle;
- else the pending override, if one is latched;
- else req_def_sel.
REQ-008 Pending override rules:
- ovr_valid without an accept SHALL latch ovr_sel as the pending override.
- A later ovr_valid SHALL replace the pending override.
- Any accept SHALL clear the pending override.
REQ-009 rsp_addr SHALL equal (zero-extended seg << SHIFT) + zero-extended req_off, truncated to ADDR_W bits, so that results wrap modulo 2^ADDR_W.
REQ-010 A write to the effective segment in the accept cycle SHALL be forwarded, so the response uses wr_data.
REQ-011 An effective select of NUM_SEGS or above SHALL use a segment value of 0 and SHALL set rsp_fault.

Reset
REQ-012 Reset SHALL act asynchronously and set:
- all segment registers to 0;
- all limit registers to all-ones;
- the pending override to cleared;
- rsp_valid, rsp_addr, rsp_seg and rsp_fault to 0.
REQ-013 Reset asserted mid-operation SHALL discard any pending response and override.
REQ-014 req_ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-015 Macro SEG_LIMIT_CHECK_EN:
- When defined, per-segment OFF_W limit registers SHALL be written by lim_wr_en, with forwarding as in REQ-010.
- When defined, rsp_fault SHALL be set when req_off is greater than the limit of the effective segment; rsp_addr SHALL still be computed.
- When undefined, no limit registers SHALL exist, lim_wr_en and lim_data SHALL be ignored, and rsp_fault SHALL be driven only by REQ-011.

Structure
REQ-016 Package seg_pkg SHALL hold:
- the segment index constants CS=0, DS=1, SS=2, ES=3, FS=4, GS=5;
- the default parameter values;
- the physical address computation as a function.
REQ-017 Sub-module seg_regfile SHALL hold the segment registers, the limit registers, the write port and forwarding read port.
REQ-018 seg_addr_unit SHALL hold the override latch, the handshake and the response register.

Verification
REQ-019 The bench SHALL cover the following scenarios, all with default parameters:
- Write CS=0x1234, then request CS with offset 0x0010 -> rsp_addr=0x12350 and rsp_seg=0x1234, one cycle after accept.
- DS=0xFFFF, request offset 0xFFFF -> rsp_addr=0x0FFEF (wrap).
- ES=0x2000, DS=0x1000, ovr_valid with ovr_sel=ES, then two DS requests with offset 0x0004 -> 0x20004, then 0x10004.
- Hold rsp_ready=0 for 3 cycles with req_valid=1 -> req_ready=0 and the response stays stable; after release, one response per cycle.
- Write SS=0x3000 in the same cycle as an SS request with offset 0 -> rsp_addr=0x30000.
- With SEG_LIMIT_CHECK_EN, DS limit=0x00FF, offset 0x0100 -> rsp_fault=1; offset 0x00FF -> rsp_fault=0; macro undefined -> rsp_fault=0 in both cases.
